m_imem_loader: RTL

Byte-stream program loader that writes 32-bit instruction words into the 4K-word instruction memory of the multicycle processor, holding the processor in reset until a complete, checked frame has been written. It sits between a byte source (UART receiver or testbench) and the memory write port (12-bit word address, write enable, 32-bit data). It is the writer side of the instruction fetch path.

---
 rtl/m_imem_loader.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/m_imem_loader.sv
// m_imem_loader
//
// Loads a program into the processor's instruction memory from a byte stream.
// The processor is held in reset until a complete, length-checked frame has
// been written.
//
// Frame: LEN0, LEN1 (word count N = {LEN1, LEN0}), then N little-endian 32-bit
// words. With LOADER_CSUM_EN defined, one more byte follows: the XOR of every
// earlier frame byte. Without the macro there is no checksum byte and no
// checksum logic.
//
// Parameters:
//   BASE      first word address written
//   ADDR_W    memory word-address width (capacity 2**ADDR_W words)
//
// Ports:
//   w_clk      clock
//   w_rst      synchronous active-low reset
//   w_din      incoming byte
//   w_valid    w_din valid this cycle
//   r_ready    loader accepts a byte this cycle
//   w_start    single-cycle restart pulse, honoured only in S_DONE / S_ERR
//   r_addr     memory word address
//   r_we       memory write enable, one-cycle pulse per word
//   r_wdata    memory write data
//   r_cpu_rst  processor reset, high unless a frame has loaded cleanly
//   r_done     frame loaded and checked
//   r_err      frame rejected
module m_imem_loader #(
    parameter int unsigned BASE   = 0,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic [7:0]        w_din,
    input  logic              w_valid,
    output logic              r_ready,
    input  logic              w_start,
    output logic [ADDR_W-1:0] r_addr,
    output logic              r_we,
    output logic [31:0]       r_wdata,
    output logic              r_cpu_rst,
    output logic              r_done,
    output logic              r_err
);

    typedef enum logic [2:0] {
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_e;

    // State entered once the last payload word (or an empty payload) is taken.
`ifdef LOADER_CSUM_EN
    localparam state_e S_TAIL = S_CSUM;
`else
    localparam state_e S_TAIL = S_DONE;
`endif

    localparam logic [32:0] CAPACITY = 33'd1 << ADDR_W;

    state_e              state_q, state_d;
    logic [7:0]          len0_q, len0_d;
    logic [15:0]         len_q, len_d;
    logic [1:0]          byte_cnt_q, byte_cnt_d;
    logic [15:0]         word_cnt_q, word_cnt_d;
    logic [23:0]         word_q, word_d;      // first three bytes of the current word
    logic                ready_q, ready_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                cpu_rst_q, cpu_rst_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
`ifdef LOADER_CSUM_EN
    logic [7:0]          csum_q, csum_d;
`endif

    logic                accept;
    logic [15:0]         len_in;
    logic [32:0]         len_end;
    logic                len_overflow;

    assign accept       = w_valid & ready_q;
    assign len_in       = {w_din, len0_q};
    // One past the last word address the frame would touch.
    assign len_end      = 33'(BASE) + 33'(len_in);
    assign len_overflow = len_end > CAPACITY;

    always_comb begin
        state_d    = state_q;
        len0_d     = len0_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        word_d     = word_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = 1'b0;
`ifdef LOADER_CSUM_EN
        csum_d     = csum_q;
        if (accept && (state_q inside {S_LEN0, S_LEN1, S_DATA})) begin
            csum_d = csum_q ^ w_din;
        end
`endif

        unique case (state_q)
            S_LEN0: begin
                if (accept) begin
                    len0_d  = w_din;
                    state_d = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    len_d = len_in;
                    if (len_overflow) begin
                        state_d = S_ERR;
                    end else if (len_in == 16'd0) begin
                        state_d = S_TAIL;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        we_d       = 1'b1;
                        addr_d     = ADDR_W'(BASE) + ADDR_W'(word_cnt_q);
                        wdata_d    = {w_din, word_q};
                        word_cnt_d = word_cnt_q + 16'd1;
                        if (word_cnt_d == len_q) begin
                            state_d = S_TAIL;
                        end
                    end else begin
                        // Shift right so byte 0 ends up in bits [7:0].
                        word_d = {w_din, word_q[23:8]};
                    end
                end
            end
            S_CSUM: begin
`ifdef LOADER_CSUM_EN
                if (accept) begin
                    state_d = (w_din == csum_q) ? S_DONE : S_ERR;
                end
`else
                state_d = S_ERR;  // unreachable without a checksum byte
`endif
            end
            S_DONE, S_ERR: begin
                if (w_start) begin
                    state_d    = S_LEN0;
                    len0_d     = 8'd0;
                    len_d      = 16'd0;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = 16'd0;
                    word_d     = 24'd0;
`ifdef LOADER_CSUM_EN
                    csum_d     = 8'd0;
`endif
                end
            end
            default: state_d = S_ERR;
        endcase

        // Status outputs are registered from the next state so they change on
        // the same edge as the state itself.
        ready_d   = !(state_d inside {S_DONE, S_ERR});
        cpu_rst_d = (state_d != S_DONE);
        done_d    = (state_d == S_DONE);
        err_d     = (state_d == S_ERR);
    end

    always_ff @(posedge w_clk) begin
        if (!w_rst) begin
            state_q    <= S_LEN0;
            len0_q     <= 8'd0;
            len_q      <= 16'd0;
            byte_cnt_q <= 2'd0;
            word_cnt_q <= 16'd0;
            word_q     <= 24'd0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= ADDR_W'(BASE);
            wdata_q    <= 32'd0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef LOADER_CSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            state_q    <= state_d;
            len0_q     <= len0_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            word_q     <= word_d;
            ready_q    <= ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef LOADER_CSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign r_ready   = ready_q;
    assign r_we      = we_q;
    assign r_addr    = addr_q;
    assign r_wdata   = wdata_q;
    assign r_cpu_rst = cpu_rst_q;
    assign r_done    = done_q;
    assign r_err     = err_q;

endmodule
